// File: rtl/tabla_arb_pkg.sv
// Shared arbitration definitions: default sizes, output-register states and
// the elaboration-time size consistency check.
package tabla_arb_pkg;

    localparam int unsigned REQ_LEN_DEFAULT = 8;
    localparam int unsigned IDX_LEN_DEFAULT = 3;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_HOLD = 1'b1
    } out_state_e;

    function automatic bit lens_ok(input int unsigned req_len, input int unsigned idx_len);
        return req_len == (32'd1 << idx_len);
    endfunction

endpackage

// File: rtl/decoder.sv
// Binary index to one-hot decoder.
module decoder #(
    parameter int unsigned inputLen = 3
) (
    input  logic [inputLen-1:0]      din,
    output logic [(1<<inputLen)-1:0] dout
);

    localparam int unsigned OUT_LEN = 1 << inputLen;

    assign dout = OUT_LEN'(1) << din;

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first candidate at or above ptr, else the
// lowest candidate, found by scanning a doubled, ptr-masked vector.
module rr_pick
    import tabla_arb_pkg::*;
#(
    parameter int unsigned reqLen = REQ_LEN_DEFAULT,
    parameter int unsigned idxLen = IDX_LEN_DEFAULT
) (
    input  logic [reqLen-1:0] cand,
    input  logic [idxLen-1:0] ptr,
    output logic              found,
    output logic [idxLen-1:0] idx
);

    logic [reqLen-1:0]   ge_mask;
    logic [2*reqLen-1:0] dbl;

    always_comb begin
        ge_mask = '0;
        for (int unsigned i = 0; i < reqLen; i++) begin
            ge_mask[i] = (idxLen'(i) >= ptr);
        end
        // Low half holds only bits at/above ptr, so it wins over the wrapped copy.
        dbl   = {cand, cand & ge_mask};
        found = |cand;
        idx   = '0;
        for (int i = int'(2 * reqLen) - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                idx = idxLen'(i);
            end
        end
    end

endmodule

// File: rtl/rr_index_encoder.sv
// Round-robin one-hot-to-binary encoder: pending set pulses are granted one
// index per cycle through a registered valid/ready output.
module rr_index_encoder
    import tabla_arb_pkg::*;
#(
    parameter int unsigned reqLen = REQ_LEN_DEFAULT,
    parameter int unsigned idxLen = IDX_LEN_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [reqLen-1:0] req_set,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [idxLen-1:0] out_idx,
    output logic [reqLen-1:0] out_onehot,
    output logic              pending_any
);

    if (!lens_ok(reqLen, idxLen)) begin : g_len_check
        $error("rr_index_encoder: reqLen must equal 1 << idxLen");
    end

    out_state_e        state_q, state_d;
    logic [reqLen-1:0] pending_q, pending_d;
    logic [idxLen-1:0] ptr_q, ptr_d;
    logic [idxLen-1:0] out_idx_q, out_idx_d;
    logic [reqLen-1:0] out_onehot_q, out_onehot_d;

    logic              hs_c;
    logic              load_c;
    logic [reqLen-1:0] clr_c;
    logic [reqLen-1:0] cand_c;
    logic              pick_found_c;
    logic [idxLen-1:0] pick_idx_c;
    logic [reqLen-1:0] onehot_dec_c;

    // Pending update and candidate set; a same-cycle set overrides the clear.
    always_comb begin
        hs_c      = (state_q == OUT_HOLD) && out_ready;
        clr_c     = hs_c ? out_onehot_q : '0;
        pending_d = (pending_q & ~clr_c) | req_set;
        cand_c    = pending_q & ~((state_q == OUT_HOLD) ? out_onehot_q : '0);
        load_c    = (state_q == OUT_IDLE) || out_ready;
    end

    rr_pick #(
        .reqLen (reqLen),
        .idxLen (idxLen)
    ) u_pick (
        .cand  (cand_c),
        .ptr   (ptr_q),
        .found (pick_found_c),
        .idx   (pick_idx_c)
    );

    // Output register next state: IDLE/HOLD, index and rotating pointer.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        out_idx_d = out_idx_q;
        if (load_c) begin
            if (pick_found_c) begin
                state_d   = OUT_HOLD;
                out_idx_d = pick_idx_c;
                ptr_d     = pick_idx_c + idxLen'(1);
            end else begin
                state_d   = OUT_IDLE;
            end
        end
    end

    decoder #(
        .inputLen (idxLen)
    ) u_dec (
        .din  (out_idx_d),
        .dout (onehot_dec_c)
    );

    assign out_onehot_d = (state_d == OUT_HOLD) ? onehot_dec_c : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= OUT_IDLE;
            pending_q    <= '0;
            ptr_q        <= '0;
            out_idx_q    <= '0;
            out_onehot_q <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            ptr_q        <= ptr_d;
            out_idx_q    <= out_idx_d;
            out_onehot_q <= out_onehot_d;
        end
    end

    assign out_valid   = (state_q == OUT_HOLD);
    assign out_idx     = out_idx_q;
    assign out_onehot  = out_onehot_q;
    assign pending_any = |pending_q;

endmodule

// File: tb/tb_rr_index_encoder.sv
// Scoreboard bench for rr_index_encoder: directed pulses push expected grant
// indices; a negedge monitor pops and compares on every handshake.
module tb_rr_index_encoder;

    localparam int unsigned REQ = 8;
    localparam int unsigned IDX = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [REQ-1:0] req_set;
    logic           out_ready;
    logic           out_valid;
    logic [IDX-1:0] out_idx;
    logic [REQ-1:0] out_onehot;
    logic           pending_any;

    int unsigned    exp_q[$];
    int             n_cmp = 0;
    int             n_err = 0;
    logic [31:0]    mon_exp;

    rr_index_encoder #(
        .reqLen (REQ),
        .idxLen (IDX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_set     (req_set),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_idx     (out_idx),
        .out_onehot  (out_onehot),
        .pending_any (pending_any)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic v, input logic [31:0] idx,
                             input logic [31:0] oh);
        check({name, "_valid"}, 32'(out_valid), 32'(v));
        check({name, "_idx"}, 32'(out_idx), idx);
        check({name, "_onehot"}, 32'(out_onehot), oh);
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            if (!out_valid && !pending_any && exp_q.size() == 0) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL %s_timeout: valid=%0b pending_any=%0b queued=%0d, expected idle",
                     name, out_valid, pending_any, exp_q.size());
        end
    endtask

    // Monitor: every accepted grant must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_grant: got idx %0d, expected none", out_idx);
            end else begin
                mon_exp = exp_q.pop_front();
                check("grant_idx", 32'(out_idx), mon_exp);
                check("grant_onehot", 32'(out_onehot), 32'd1 << mon_exp);
            end
        end
    end

    initial begin
        reset     = 1'b0;
        req_set   = 8'hFF;
        out_ready = 1'b0;

        // Reset holds everything at zero even with requests asserted.
        repeat (3) tick();
        check_out("reset", 1'b0, 0, 0);
        check("reset_pending_any", 32'(pending_any), 0);
        req_set = '0;
        reset   = 1'b1;
        tick();

        // First grant after reset is idx 0.
        req_set = 8'h01; out_ready = 1'b1; exp_q.push_back(0);
        tick();
        req_set = '0;
        wait_idle("first");

        // Single request: valid two edges after issue, idle and empty on the third.
        req_set = 8'h04; exp_q.push_back(2);
        tick();
        req_set = '0;
        check("single_pend_any", 32'(pending_any), 1);
        check("single_early_valid", 32'(out_valid), 0);
        tick();
        check_out("single", 1'b1, 2, 32'h04);
        tick();
        check("single_done_valid", 32'(out_valid), 0);
        check("single_done_pend", 32'(pending_any), 0);

        // Reset pulse returns ptr to 0, then a full sweep 0..7.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        req_set = 8'hFF;
        for (int k = 0; k < 8; k++) exp_q.push_back(k);
        tick();
        req_set = '0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_out("sweep", 1'b1, k, 32'd1 << k);
        end
        tick();
        check("sweep_end_valid", 32'(out_valid), 0);

        // Backpressure: idx 0 held five cycles, then 0, 2, idle.
        out_ready = 1'b0;
        req_set   = 8'h05; exp_q.push_back(0); exp_q.push_back(2);
        tick();
        req_set = '0;
        tick();
        for (int k = 0; k < 5; k++) begin
            check_out("bp_hold", 1'b1, 0, 32'h01);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check_out("bp_next", 1'b1, 2, 32'h04);
        tick();
        check("bp_idle", 32'(out_valid), 0);

        // Wrap: grant 5 so ptr=6, then 0x41 must give 6 before 0.
        req_set = 8'h20; exp_q.push_back(5);
        tick();
        req_set = '0;
        wait_idle("wrap_pre");
        req_set = 8'h41; exp_q.push_back(6); exp_q.push_back(0);
        tick();
        req_set = '0;
        wait_idle("wrap");

        // Collision: idx 3 handshake while re-setting bit 3 -> 7, then 3 again.
        out_ready = 1'b0;
        req_set   = 8'h88; exp_q.push_back(3);
        tick();
        req_set = '0;
        tick();
        check_out("coll_hold", 1'b1, 3, 32'h08);
        out_ready = 1'b1;
        req_set   = 8'h08; exp_q.push_back(7); exp_q.push_back(3);
        tick();
        req_set = '0;
        check_out("coll_seven", 1'b1, 7, 32'h80);
        wait_idle("coll");

        // Asynchronous reset mid-stream drops the held grant immediately.
        out_ready = 1'b0;
        req_set   = 8'hF0;
        tick();
        req_set = '0;
        tick();
        check("mid_valid_before", 32'(out_valid), 1);
        #2 reset = 1'b0;
        #1;
        check_out("mid_reset", 1'b0, 0, 0);
        check("mid_reset_pend", 32'(pending_any), 0);
        #3 reset = 1'b1;
        req_set = 8'h01; out_ready = 1'b1; exp_q.push_back(0);
        tick();
        req_set = '0;
        tick();
        check_out("post_reset", 1'b1, 0, 32'h01);
        wait_idle("post_reset");

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
